// File: rtl/div_chk_pkg.sv
// div_chk_pkg: FSM state type and the period-quality rule shared by div_clk_checker.
package div_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED,
    FAULT
  } chk_state_e;

  localparam int DUTY_TOL_ODD  = 1;
  localparam int DUTY_TOL_EVEN = 0;

  // Odd ratios cannot split evenly, so they allow a one-cycle high/low imbalance.
  function automatic logic period_good(input int high_len, input int low_len, input int div_n);
    int tol;
    int diff;
    tol  = (div_n % 2 != 0) ? DUTY_TOL_ODD : DUTY_TOL_EVEN;
    diff = (high_len > low_len) ? high_len - low_len : low_len - high_len;
    return (high_len + low_len == div_n) && (diff <= tol);
  endfunction

endpackage

// File: rtl/div_clk_checker_if.sv
// div_clk_checker_if: divided-clock input, restart control and checker status outputs.
interface div_clk_checker_if #(
  parameter int CNT_W = 4,
  parameter int ERR_W = 8
);
  logic             div_in;
  logic             clr;
  logic             rise_pulse;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;

  modport master (
    output div_in, clr,
    input  rise_pulse, locked, err, err_cnt, high_len, low_len
  );

  modport slave (
    input  div_in, clr,
    output rise_pulse, locked, err, err_cnt, high_len, low_len
  );
endinterface

// File: rtl/div_edge_meter.sv
// div_edge_meter: samples the divided clock as data, detects edges and measures run lengths.
// Defining DIV_CLK_CHECKER_SYNC_EN inserts a 2-flop synchronizer ahead of the sample flop.
module div_edge_meter #(
  parameter int DIV_N = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             div_in_i,
  output logic             rise_o,
  output logic             stuck_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] high_len_o,
  output logic [CNT_W-1:0] low_len_o
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STUCK_LEN = CNT_W'(DIV_N);

  logic             din;
  logic             s_q;
  logic             prev_q;
  logic             stuck_done_q;
  logic             fall;
  logic             edge_seen;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] high_len_q;
  logic [CNT_W-1:0] low_len_q;

`ifdef DIV_CLK_CHECKER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[0], div_in_i};
  end
  assign din = sync_q[1];
`else
  assign din = div_in_i;
`endif

  assign rise_o    = s_q & ~prev_q;
  assign fall      = ~s_q & prev_q;
  assign edge_seen = rise_o | fall;
  // Flag a stuck run once, even when DIV_N equals the saturation value.
  assign stuck_o   = ~edge_seen & (cnt_q == STUCK_LEN) & ~stuck_done_q;

  // NOTE: a combinational block assigns a default first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (edge_seen)             cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q          <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      stuck_done_q <= 1'b0;
    end else begin
      s_q          <= din;
      prev_q       <= s_q;
      cnt_q        <= cnt_d;
      stuck_done_q <= edge_seen ? 1'b0 : (stuck_done_q | stuck_o);
      if (fall)   high_len_q <= cnt_q;
      if (rise_o) low_len_q  <= cnt_q;
    end
  end

  assign cnt_o      = cnt_q;
  assign high_len_o = high_len_q;
  assign low_len_o  = low_len_q;

endmodule

// File: rtl/div_clk_checker.sv
// div_clk_checker: checks the ratio and duty of a divided clock sampled as data and reports lock/faults.
// The optional input synchronizer (DIV_CLK_CHECKER_SYNC_EN) lives in div_edge_meter.
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int DIV_N    = 9,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 4,
  parameter int ERR_W    = 8
) (
  input logic               clk,
  input logic               rstn,
  div_clk_checker_if.slave  bus
);
  localparam int               GC_W     = 4;
  localparam logic [GC_W-1:0]  LOCK_TGT = GC_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic             rise;
  logic             stuck;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             shape_ok;
  logic             good_p;
  logic             bad_p;

  chk_state_e       state_q;
  logic [GC_W-1:0]  good_cnt_q;
  logic             locked_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  div_edge_meter #(
    .DIV_N (DIV_N),
    .CNT_W (CNT_W)
  ) u_meter (
    .clk        (clk),
    .rstn       (rstn),
    .div_in_i   (bus.div_in),
    .rise_o     (rise),
    .stuck_o    (stuck),
    .cnt_o      (cnt),
    .high_len_o (high_len),
    .low_len_o  (low_len)
  );

  // At a rise the counter still holds the low run that just ended; high_len is from the prior fall.
  assign shape_ok = period_good(int'(high_len), int'(cnt), DIV_N);
  assign good_p   = rise & shape_ok;
  assign bad_p    = stuck | (rise & ~shape_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else if (bus.clr) begin
      state_q    <= IDLE;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          state_q    <= ACQ;
          good_cnt_q <= '0;
        end
        ACQ: if (good_p) begin
          good_cnt_q <= good_cnt_q + 1'b1;
          if (good_cnt_q + 1'b1 >= LOCK_TGT) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end else if (bad_p) begin
          good_cnt_q <= '0;
        end
        LOCKED: if (bad_p) begin
          err_q    <= 1'b1;
          state_q  <= FAULT;
          locked_q <= 1'b0;
          if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
        end
        FAULT: if (good_p) begin
          state_q    <= ACQ;
          good_cnt_q <= GC_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rise_pulse = rise;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.high_len   = high_len;
  assign bus.low_len    = low_len;

endmodule

// File: tb/tb_div_clk_checker.sv
// tb_div_clk_checker: table-driven and randomized check of div_clk_checker against a sample-history model.
module tb_div_clk_checker;
  localparam int DIV_N    = 9;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 4;
  localparam int ERR_W    = 8;
  localparam int ERR_W2   = 2;
  localparam int SAT      = (1 << CNT_W) - 1;
`ifdef DIV_CLK_CHECKER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_ACQ   = 1;
  localparam int S_LOCK  = 2;
  localparam int S_FAULT = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  div_clk_checker_if #(.CNT_W(CNT_W), .ERR_W(ERR_W))  bus ();
  div_clk_checker_if #(.CNT_W(CNT_W), .ERR_W(ERR_W2)) bus2 ();
  assign bus2.div_in = bus.div_in;
  assign bus2.clr    = bus.clr;

  div_clk_checker #(.DIV_N(DIV_N), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk (clk), .rstn (rstn), .bus (bus.slave)
  );
  div_clk_checker #(.DIV_N(DIV_N), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W), .ERR_W(ERR_W2)) dut2 (
    .clk (clk), .rstn (rstn), .bus (bus2.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: history of sampled values ----------------
  bit hist[$];
  bit pipe[$];
  bit cur_rise, cur_fall, cur_stuck;
  int cur_run;
  int m_state, m_gc, m_errs, m_high, m_low;
  bit m_locked, m_err;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic analyse_last();
    int t = hist.size() - 1;
    cur_rise = 0; cur_fall = 0; cur_stuck = 0; cur_run = 0;
    if (t > 0) begin
      bit pv = hist[t-1];
      for (int j = t - 1; j >= 0 && hist[j] == pv; j--) cur_run++;
      cur_rise  = hist[t] & ~pv;
      cur_fall  = ~hist[t] & pv;
      cur_stuck = (hist[t] == pv) && (cur_run == DIV_N);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    pipe.delete();
    hist.push_back(1'b0);
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(1'b0);
    m_state = S_IDLE; m_gc = 0; m_errs = 0; m_high = 0; m_low = 0;
    m_locked = 0; m_err = 0;
    analyse_last();
  endtask

  task automatic model_tick(input bit din, input bit clr);
    int run_len, diff;
    bit shape_ok, good_p, bad_p;
    run_len  = sat(cur_run);
    diff     = (m_high > run_len) ? m_high - run_len : run_len - m_high;
    shape_ok = (m_high + run_len == DIV_N) && (diff <= DIV_N % 2);
    good_p   = cur_rise && shape_ok;
    bad_p    = cur_stuck || (cur_rise && !shape_ok);
    m_err    = 0;
    if (clr) begin
      m_state = S_IDLE; m_gc = 0; m_errs = 0; m_locked = 0;
    end else begin
      case (m_state)
        S_IDLE: if (cur_rise) begin m_state = S_ACQ; m_gc = 0; end
        S_ACQ: begin
          if (good_p) begin
            m_gc++;
            if (m_gc >= LOCK_CNT) begin m_state = S_LOCK; m_locked = 1; end
          end else if (bad_p) m_gc = 0;
        end
        S_LOCK: if (bad_p) begin m_err = 1; m_errs++; m_state = S_FAULT; m_locked = 0; end
        default: if (good_p) begin m_state = S_ACQ; m_gc = 1; end
      endcase
    end
    if (cur_fall) m_high = run_len;
    if (cur_rise) m_low  = run_len;
    pipe.push_back(din);
    hist.push_back(pipe.pop_front());
    analyse_last();
  endtask

  task automatic compare_all();
    check("rise_pulse", bus.rise_pulse, cur_rise);
    check("locked",     bus.locked,     m_locked);
    check("err",        bus.err,        m_err);
    check("err_cnt",    bus.err_cnt,    min_i(m_errs, 255));
    check("high_len",   bus.high_len,   m_high);
    check("low_len",    bus.low_len,    m_low);
    check("err_cnt_w2", bus2.err_cnt,   min_i(m_errs, 3));
    check("err_w2",     bus2.err,       m_err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"},   bus.rise_pulse, 0);
    check({tag, "_locked"}, bus.locked,     0);
    check({tag, "_err"},    bus.err,        0);
    check({tag, "_errcnt"}, bus.err_cnt,    0);
    check({tag, "_high"},   bus.high_len,   0);
    check({tag, "_low"},    bus.low_len,    0);
    check({tag, "_errcnt2"}, bus2.err_cnt,  0);
  endtask

  // One clock of stimulus; called #1 after an active edge.
  task automatic step(input bit d, input bit c);
    bus.div_in = d;
    bus.clr    = c;
    @(posedge clk);
    model_tick(d, c);
    #1;
    compare_all();
  endtask

  // ---------------- directed table: low phase, high phase, expectations ----------------
  typedef struct {
    int lo;
    int hi;
    bit clr;
    bit exp_locked;
    int exp_errs;
  } row_t;

  row_t rows[$];

  task automatic add_row(input int lo, input int hi, input bit c, input bit lk, input int e, input int n);
    row_t r;
    r.lo = lo; r.hi = hi; r.clr = c; r.exp_locked = lk; r.exp_errs = e;
    for (int i = 0; i < n; i++) rows.push_back(r);
  endtask

  // clr, when set, is applied on the last high cycle, after the rise has been evaluated.
  task automatic run_row(input row_t r, input int idx);
    for (int i = 0; i < r.lo; i++) step(1'b0, 1'b0);
    for (int i = 0; i < r.hi; i++) step(1'b1, r.clr && (i == r.hi - 1));
    check($sformatf("row%0d_locked", idx), bus.locked, r.exp_locked);
    check($sformatf("row%0d_err_cnt", idx), bus.err_cnt, r.exp_errs);
    check($sformatf("row%0d_err_cnt_w2", idx), bus2.err_cnt, (r.exp_errs > 3) ? 3 : r.exp_errs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi;
    bit c;

    rstn       = 1'b0;
    bus.div_in = 1'b0;
    bus.clr    = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    add_row(4, 5, 0, 0, 0, 4);  // first rise acquires, then good periods
    add_row(4, 5, 0, 1, 0, 1);  // 5th rise: lock
    add_row(4, 6, 0, 1, 0, 1);  // long high, judged at next rise
    add_row(4, 5, 0, 0, 1, 4);  // 6+4 bad -> FAULT, then relock
    add_row(4, 5, 0, 1, 1, 1);
    add_row(20, 5, 0, 0, 2, 1); // stuck low -> single err
    add_row(4, 5, 0, 0, 2, 3);
    add_row(4, 5, 0, 1, 2, 1);
    add_row(3, 5, 0, 0, 3, 1);  // 5+3 short period
    add_row(4, 5, 0, 0, 3, 3);
    add_row(4, 5, 0, 1, 3, 1);
    add_row(5, 5, 0, 0, 4, 1);  // 5+5 period; 2-bit counter saturates
    add_row(4, 5, 0, 0, 4, 3);
    add_row(4, 5, 0, 1, 4, 1);
    add_row(4, 5, 1, 0, 0, 1);  // clr while locked
    add_row(4, 5, 0, 0, 0, 4);  // fresh rise then 4 good periods
    add_row(4, 5, 0, 1, 0, 1);

    foreach (rows[i]) run_row(rows[i], i);

    // Reset in the middle of a high run: everything clears at once.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    bus.div_in = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) run_row(rows[i], 100 + i);

    // Randomized periods, mostly ideal with occasional distortions and restarts.
    for (int p = 0; p < 150; p++) begin
      lo = ($urandom_range(9, 0) == 0) ? int'($urandom_range(12, 2)) : 4;
      hi = ($urandom_range(9, 0) == 0) ? int'($urandom_range(8, 3))  : 5;
      c  = ($urandom_range(29, 0) == 0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
      for (int i = 0; i < hi; i++) step(1'b1, c && (i == hi - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
